bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Round-robin arbiter for the shared system bus. Up to NREQ masters (ICache at index 0, future DCache/DMA at higher indices) request the bus.
- Issues a registered one-hot bus_ack and holds it for a multi-beat transaction.
- Optionally preempts a long-holding owner when others wait.
- Sits between masters' bus_req lines and the address/data mux in System. The mux selects using bus_owner/bus_ack.

Parameters:
- NREQ, 8, number of requester slots; bus_req/bus_ack width.
- IDXW, 3, width of owner index; must satisfy 2**IDXW >= NREQ.
- MAX_BEATS, 0, bus_ready beats after which the owner is preempted if another request is pending. 0 disables preemption.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- Nrst  in  1  reset, asynchronous, active-low.
- bus_req  in  NREQ  per-master request; a master holds it high for its whole transaction.
- bus_ready  in  1  slave beat-complete strobe for the current transfer.
- bus_ack  out  NREQ  registered one-hot grant; all-zero when the bus is idle.
- bus_owner  out  IDXW  index of the current or most recent owner; valid when bus_busy=1.
- bus_busy  out  1  high while any bus_ack bit is high.

Behaviour:
- Reset (Nrst low, asynchronous):
  - bus_ack=0, bus_busy=0, bus_owner=0, beat counter=0, state=IDLE.
  - last pointer=NREQ-1, so the first grant searches from index 0.
  - Reset mid-grant drops bus_ack immediately, without waiting for a clock edge.
- FSM has two states, IDLE and OWNED. All outputs are registered.
- IDLE:
  - If bus_req is nonzero, pick winner = first set bit searching last+1, last+2, … wrapping modulo NREQ.
  - Set bus_ack<=onehot(winner), bus_owner<=winner, bus_busy<=1, beats<=0, state<=OWNED.
  - If bus_req is zero, stay in IDLE with outputs 0.
- Grant latency: a request seen at edge E with the FSM in IDLE gives bus_ack high in the cycle after E.
- OWNED, release:
  - If bus_req[bus_owner]=0: bus_ack<=0, bus_busy<=0, last<=bus_owner, state<=IDLE.
  - bus_owner keeps its value.
- OWNED, beat counting:
  - Else, if bus_ready=1, beats increments.
  - beats saturates at MAX_BEATS, or at 2**16-1 when MAX_BEATS=0.
- OWNED, preemption:
  - Applies when MAX_BEATS≠0, beats==MAX_BEATS, and some other bus_req bit is set.
  - Action is the same as release: ack<=0, last<=owner, state<=IDLE.
  - The owner must re-request and waits its round-robin turn.
  - A beat arriving on the preemption edge is not counted.
- Dead cycle: there is always exactly one cycle with bus_ack=0 between two consecutive grants, including a re-grant to the same master. The bus mux settles during this cycle.
- Fairness: a requester that keeps bus_req asserted is granted within NREQ-1 intervening grants.
- Ignored inputs:
  - bus_ready in IDLE.
  - Request bits at index ≥NREQ, which do not exist.
- Simultaneous release and new requests: the release edge goes to IDLE, and arbitration happens on the next edge. Release never grants on the same edge.
- Invariant: bus_ack is always zero-hot or one-hot. Assert this in simulation.

Decomposition:
- Shared package bus_pkg:
  - NREQ.
  - Slot indices BUS_ICACHE=0, BUS_DCACHE=1, BUS_DMA=2.
  - State encoding localparams ST_IDLE/ST_OWNED.
- One sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: req[NREQ], last[IDXW].
  - Outputs: any, winner[IDXW].
  - Implemented by rotating req, priority-encoding, then adding last+1 modulo NREQ.
- The top level holds the FSM, beat counter and registers.

Test Plan:
- Reset: hold Nrst=0 with bus_req=8'hFF → bus_ack=0, bus_busy=0.
  - Release Nrst → bus_ack=8'h01 one cycle later, bus_owner=0.
- Single master: bus_req=8'h01 for 5 cycles with bus_ready pulsing, then drop.
  - bus_ack=8'h01 for 5 cycles, then 0.
  - bus_busy follows bus_ack exactly.
- Round robin: bus_req=8'h05 held, each owner releasing after 2 cycles and re-asserting.
  - Grant sequence 01, 04, 01, 04, with one zero cycle between each grant.
- Wrap: last=7 with bus_req=8'h81 → next grant 8'h01. Then request 8'h80 after release → grant 8'h80.
- Preemption, MAX_BEATS=4: master 0 holds with bus_ready every cycle and master 2 requests.
  - After the 4th beat, bus_ack drops to 0; next cycle bus_ack=8'h04.
  - With MAX_BEATS=0, no drop occurs.
- Reset mid-grant: owner 2 active, Nrst pulsed low between clock edges → bus_ack=0 immediately.
  - After release, with 8'h04 still requested → grant 8'h04, because the search restarts from 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants for the system-bus arbiter: requester slot map, default sizing, FSM encoding.
package bus_pkg;
   localparam int   NREQ       = 8;
   localparam int   IDXW       = 3;

   localparam int   BUS_ICACHE = 0;
   localparam int   BUS_DCACHE = 1;
   localparam int   BUS_DMA    = 2;

   localparam logic ST_IDLE    = 1'b0;
   localparam logic ST_OWNED   = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first set request strictly after 'last', wrapping modulo NREQ.
// Purely combinational; any=0 (winner meaningless) when nothing is requested.
module rr_pick #(
   parameter int NREQ = bus_pkg::NREQ,
   parameter int IDXW = bus_pkg::IDXW
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] last,
   output logic            any,
   output logic [IDXW-1:0] winner
);
   logic [IDXW-1:0]   w_start;
   logic [2*NREQ-1:0] w_dbl;
   logic [NREQ-1:0]   w_rot;
   logic [IDXW-1:0]   w_pos;
   logic [IDXW:0]     w_sum;

   always_comb begin
      w_start = (last == IDXW'(NREQ-1)) ? '0 : last + 1'b1;
      // rotate so bit 0 of w_rot is the highest-priority slot
      w_dbl   = {req, req} >> w_start;
      w_rot   = w_dbl[NREQ-1:0];
      w_pos   = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (w_rot[i]) w_pos = IDXW'(i);
      end
      w_sum   = {1'b0, w_pos} + {1'b0, w_start};
      if (w_sum >= (IDXW+1)'(NREQ)) w_sum = w_sum - (IDXW+1)'(NREQ);
      winner  = w_sum[IDXW-1:0];
      any     = |req;
   end
endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin system-bus arbiter: registered one-hot grant, held until the owner drops its request.
// Grant one cycle after request; one dead cycle between grants; optional preemption after MAX_BEATS beats.
module bus_arbiter_rr #(
   parameter int NREQ      = bus_pkg::NREQ,
   parameter int IDXW      = bus_pkg::IDXW,
   parameter int MAX_BEATS = 0
) (
   input  logic            clk,
   input  logic            Nrst,
   input  logic [NREQ-1:0] bus_req,
   input  logic            bus_ready,
   output logic [NREQ-1:0] bus_ack,
   output logic [IDXW-1:0] bus_owner,
   output logic            bus_busy
);
   import bus_pkg::*;

   localparam logic [15:0] BEAT_SAT = (MAX_BEATS == 0) ? 16'hFFFF : 16'(MAX_BEATS);

   logic            r_state;
   logic            w_state_nxt;
   logic [NREQ-1:0] r_ack;
   logic [NREQ-1:0] w_ack_nxt;
   logic [IDXW-1:0] r_owner;
   logic [IDXW-1:0] w_owner_nxt;
   logic [IDXW-1:0] r_last;
   logic [IDXW-1:0] w_last_nxt;
   logic            r_busy;
   logic            w_busy_nxt;
   logic [15:0]     r_beats;
   logic [15:0]     w_beats_nxt;

   logic            w_any;
   logic [IDXW-1:0] w_winner;
   logic            w_others;
   logic            w_release;
   logic            w_preempt;

   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_pick (
      .req    (bus_req),
      .last   (r_last),
      .any    (w_any),
      .winner (w_winner)
   );

   assign w_others  = |(bus_req & ~r_ack);
   assign w_release = ~bus_req[r_owner];
   assign w_preempt = (MAX_BEATS != 0) && (r_beats == BEAT_SAT) && w_others;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_any) w_state_nxt = ST_OWNED;
         ST_OWNED: if (w_release || w_preempt) w_state_nxt = ST_IDLE;
      endcase
   end

   // Release and preemption both return to IDLE; arbitration waits for the next edge (dead cycle).
   always_comb begin
      w_ack_nxt   = r_ack;
      w_busy_nxt  = r_busy;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      w_beats_nxt = r_beats;
      if (r_state == ST_IDLE) begin
         if (w_any) begin
            w_ack_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
            w_owner_nxt = w_winner;
            w_busy_nxt  = 1'b1;
            w_beats_nxt = '0;
         end
      end else if (w_release || w_preempt) begin
         w_ack_nxt  = '0;
         w_busy_nxt = 1'b0;
         w_last_nxt = r_owner;
      end else if (bus_ready && (r_beats != BEAT_SAT)) begin
         w_beats_nxt = r_beats + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge Nrst) begin
      if (!Nrst) begin
         r_state <= ST_IDLE;
         r_ack   <= '0;
         r_busy  <= 1'b0;
         r_owner <= '0;
         r_last  <= IDXW'(NREQ-1);
         r_beats <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_ack_nxt;
         r_busy  <= w_busy_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
         r_beats <= w_beats_nxt;
      end
   end

   assign bus_ack   = r_ack;
   assign bus_owner = r_owner;
   assign bus_busy  = r_busy;

   a_ack_onehot0: assert property (@(posedge clk) disable iff (!Nrst) $onehot0(r_ack));
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed request patterns, grant scoreboard plus per-cycle sample expectations.
// dut runs with MAX_BEATS=4, dut0 with preemption disabled; both share all inputs.
module tb_bus_arbiter_rr;
   typedef struct {
      logic [7:0] ack;
      logic [2:0] owner;
      int         len;
   } grant_t;

   typedef struct {
      bit         which;
      logic [7:0] ack;
      logic       busy;
      logic [2:0] owner;
      int         tag;
   } samp_t;

   logic       clk       = 1'b0;
   logic       Nrst      = 1'b0;
   logic [7:0] bus_req   = 8'h00;
   logic       bus_ready = 1'b0;

   logic [7:0] ack_a, ack_b;
   logic [2:0] own_a, own_b;
   logic       busy_a, busy_b;

   grant_t gq[$];
   samp_t  sq[$];
   int     checks   = 0;
   int     failures = 0;
   bit     done     = 1'b0;
   bit     final_done = 1'b0;

   always #5 clk = ~clk;

   bus_arbiter_rr #(.NREQ(8), .IDXW(3), .MAX_BEATS(4)) dut (
      .clk(clk), .Nrst(Nrst), .bus_req(bus_req), .bus_ready(bus_ready),
      .bus_ack(ack_a), .bus_owner(own_a), .bus_busy(busy_a)
   );

   bus_arbiter_rr #(.NREQ(8), .IDXW(3), .MAX_BEATS(0)) dut0 (
      .clk(clk), .Nrst(Nrst), .bus_req(bus_req), .bus_ready(bus_ready),
      .bus_ack(ack_b), .bus_owner(own_b), .bus_busy(busy_b)
   );

   // Monitor: all comparisons happen here, on the falling edge.
   logic       in_g = 1'b0;
   logic [7:0] cur_ack;
   logic [2:0] cur_own;
   int         cur_len;

   always @(negedge clk) begin
      grant_t     g;
      samp_t      s;
      logic [7:0] a_ack;
      logic       a_busy;
      logic [2:0] a_own;

      checks++;
      if (busy_a !== (ack_a != 8'h00)) begin
         failures++;
         $display("FAIL busy_track_dut ack=%h busy=%b required busy=%b", ack_a, busy_a, (ack_a != 8'h00));
      end
      checks++;
      if (busy_b !== (ack_b != 8'h00)) begin
         failures++;
         $display("FAIL busy_track_dut0 ack=%h busy=%b required busy=%b", ack_b, busy_b, (ack_b != 8'h00));
      end
      checks++;
      if (!$onehot0(ack_a) || !$onehot0(ack_b)) begin
         failures++;
         $display("FAIL onehot0 ack=%h ack0=%h required zero- or one-hot", ack_a, ack_b);
      end

      if (ack_a != 8'h00) begin
         if (!in_g) begin
            in_g    = 1'b1;
            cur_ack = ack_a;
            cur_own = own_a;
            cur_len = 1;
         end else begin
            cur_len++;
            if (ack_a != cur_ack) begin
               checks++;
               failures++;
               $display("FAIL dead_cycle ack changed %h->%h required a zero cycle between grants", cur_ack, ack_a);
               cur_ack = ack_a;
            end
         end
      end else if (in_g) begin
         in_g = 1'b0;
         checks++;
         if (gq.size() == 0) begin
            failures++;
            $display("FAIL grant_unexpected ack=%h owner=%0d len=%0d required no grant", cur_ack, cur_own, cur_len);
         end else begin
            g = gq.pop_front();
            if (cur_ack != g.ack || cur_own != g.owner || (g.len != 0 && cur_len != g.len)) begin
               failures++;
               $display("FAIL grant ack=%h owner=%0d len=%0d required ack=%h owner=%0d len=%0d",
                        cur_ack, cur_own, cur_len, g.ack, g.owner, g.len);
            end
         end
      end

      while (sq.size() > 0) begin
         s      = sq.pop_front();
         a_ack  = s.which ? ack_b  : ack_a;
         a_busy = s.which ? busy_b : busy_a;
         a_own  = s.which ? own_b  : own_a;
         checks++;
         if (a_ack !== s.ack || a_busy !== s.busy || a_own !== s.owner) begin
            failures++;
            $display("FAIL sample%0d dut%0d ack=%h busy=%b owner=%0d required ack=%h busy=%b owner=%0d",
                     s.tag, s.which, a_ack, a_busy, a_own, s.ack, s.busy, s.owner);
         end
      end

      if (done && !final_done) begin
         final_done = 1'b1;
         checks++;
         if (gq.size() != 0 || in_g) begin
            failures++;
            $display("FAIL grants_outstanding pending=%0d in_grant=%b required 0/0", gq.size(), in_g);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [7:0] r, input logic rdy);
      bus_req   = r;
      bus_ready = rdy;
      tick();
   endtask

   task automatic expg(input logic [7:0] a, input logic [2:0] o, input int l);
      grant_t g;
      g.ack   = a;
      g.owner = o;
      g.len   = l;
      gq.push_back(g);
   endtask

   task automatic exps(input bit w, input logic [7:0] a, input logic b, input logic [2:0] o, input int t);
      samp_t s;
      s.which = w;
      s.ack   = a;
      s.busy  = b;
      s.owner = o;
      s.tag   = t;
      sq.push_back(s);
   endtask

   logic [7:0] rr_vec [13] = '{8'h05, 8'h05, 8'h01, 8'h05, 8'h05, 8'h04,
                               8'h05, 8'h05, 8'h01, 8'h05, 8'h05, 8'h04, 8'h00};
   logic [7:0] wr_vec [10] = '{8'h80, 8'h80, 8'h00, 8'h81, 8'h81, 8'h80,
                               8'h80, 8'h80, 8'h00, 8'h00};

   initial begin
      // Reset held with every master requesting; first grant goes to slot 0.
      expg(8'h01, 3'd0, 1);
      for (int k = 0; k < 3; k++) begin
         apply(8'hFF, 1'b0);
         exps(1'b0, 8'h00, 1'b0, 3'd0, 1);
         exps(1'b1, 8'h00, 1'b0, 3'd0, 2);
      end
      Nrst = 1'b1;
      apply(8'hFF, 1'b0);
      exps(1'b0, 8'h01, 1'b1, 3'd0, 3);
      apply(8'h00, 1'b0);
      apply(8'h00, 1'b0);

      // Single master, five-cycle transaction with pulsing bus_ready.
      expg(8'h01, 3'd0, 5);
      for (int k = 0; k < 5; k++) apply(8'h01, (k % 2) == 0);
      apply(8'h00, 1'b0);
      exps(1'b0, 8'h00, 1'b0, 3'd0, 4);
      apply(8'h00, 1'b0);

      // Slots 0 and 2 alternate; last owner was 0 so slot 2 goes first.
      expg(8'h04, 3'd2, 2);
      expg(8'h01, 3'd0, 2);
      expg(8'h04, 3'd2, 2);
      expg(8'h01, 3'd0, 2);
      for (int k = 0; k < 13; k++) begin
         apply(rr_vec[k], 1'b0);
         if (k == 2) exps(1'b0, 8'h00, 1'b0, 3'd2, 5);
         if (k == 3) exps(1'b0, 8'h01, 1'b1, 3'd0, 6);
      end

      // Wrap: owner 7 releases, search wraps to slot 0, then back to 7.
      expg(8'h80, 3'd7, 2);
      expg(8'h01, 3'd0, 2);
      expg(8'h80, 3'd7, 2);
      for (int k = 0; k < 10; k++) begin
         apply(wr_vec[k], 1'b0);
         if (k == 3) exps(1'b0, 8'h01, 1'b1, 3'd0, 7);
      end

      // Preemption: slot 0 streams beats while slot 2 waits.
      expg(8'h01, 3'd0, 5);
      expg(8'h04, 3'd2, 2);
      for (int k = 0; k < 10; k++) begin
         apply((k < 8) ? 8'h05 : ((k == 8) ? 8'h01 : 8'h00), 1'b1);
         exps(1'b1, (k < 9) ? 8'h01 : 8'h00, k < 9, 3'd0, 100 + k);
         if (k == 5) exps(1'b0, 8'h00, 1'b0, 3'd0, 8);
         if (k == 6) exps(1'b0, 8'h04, 1'b1, 3'd2, 9);
      end

      // Reset pulsed mid-grant between edges drops the grant asynchronously.
      expg(8'h04, 3'd2, 0);
      apply(8'h04, 1'b0);
      apply(8'h04, 1'b0);
      #2;
      Nrst = 1'b0;
      #1;
      exps(1'b0, 8'h00, 1'b0, 3'd0, 10);
      exps(1'b1, 8'h00, 1'b0, 3'd0, 11);
      tick();
      tick();
      Nrst = 1'b1;
      expg(8'h04, 3'd2, 2);
      apply(8'h04, 1'b0);
      exps(1'b0, 8'h04, 1'b1, 3'd2, 12);
      apply(8'h04, 1'b0);
      apply(8'h00, 1'b0);
      apply(8'h00, 1'b0);

      done = 1'b1;
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1);
   end
endmodule
